regfile_alu_sequencer: RTL and testbench

- Command-driven controller for the 32x64 register file plus LEGv8 ALU datapath.
- Accepts one register-level command per valid/ready handshake.
- Drives the datapath control word (W, EN_ALU, EN_B, K_SEL, C0, SA, SB, DA, FS, K) for one or three cycles, then returns to idle.
- Captures ALU Status into a flags register and provides a multi-cycle SWAP through a scratch register.

---
 rtl/regfile_alu_sequencer_pkg.sv | 53 +++++
 rtl/regfile_alu_sequencer_seq_op_decode.sv | 59 +++++
 rtl/regfile_alu_sequencer.sv | 156 +++++++++++++++
 tb/tb_regfile_alu_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_alu_sequencer_pkg.sv
// Shared opcodes, ALU function selects and FSM encoding for the
// register-file/ALU command sequencer.
package regfile_alu_seq_pkg;

  // Command opcodes (4'hC..4'hF are illegal)
  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ORR  = 4'h4;
  localparam logic [3:0] OP_EOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_SUBI = 4'h7;
  localparam logic [3:0] OP_LSL  = 4'h8;
  localparam logic [3:0] OP_LSR  = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_SWAP = 4'hB;

  // FS[4:2] picks the function, FS[1] inverts A, FS[0] inverts B
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_SW1  = 3'd2,
    ST_SW2  = 3'd3,
    ST_SW3  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Static datapath settings implied by an opcode
  typedef struct packed {
    logic [4:0] fs;
    logic       c0;
    logic       k_sel;
    logic       en_alu;
    logic       en_b;
    logic       w;
    logic       setf_allowed;
    logic       legal;
  } op_ctrl_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_SWAP);
  endfunction

endpackage

// File: rtl/regfile_alu_sequencer_seq_op_decode.sv
// Combinational decode of the registered opcode into datapath settings.
module seq_op_decode
  import regfile_alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output op_ctrl_t   ctrl
);

  // Opcode lookup; anything not listed stays illegal with all controls low
  always_comb begin
    ctrl = '0;
    unique case (op)
      OP_MOV: begin
        ctrl.en_b = 1'b1; ctrl.w = 1'b1; ctrl.legal = 1'b1;
      end
      OP_ADD: begin
        ctrl.fs = FS_ADD; ctrl.en_alu = 1'b1; ctrl.w = 1'b1;
        ctrl.setf_allowed = 1'b1; ctrl.legal = 1'b1;
      end
      OP_SUB: begin
        ctrl.fs = FS_SUB; ctrl.c0 = 1'b1; ctrl.en_alu = 1'b1; ctrl.w = 1'b1;
        ctrl.setf_allowed = 1'b1; ctrl.legal = 1'b1;
      end
      OP_AND: begin
        ctrl.fs = FS_AND; ctrl.en_alu = 1'b1; ctrl.w = 1'b1; ctrl.legal = 1'b1;
      end
      OP_ORR: begin
        ctrl.fs = FS_OR; ctrl.en_alu = 1'b1; ctrl.w = 1'b1; ctrl.legal = 1'b1;
      end
      OP_EOR: begin
        ctrl.fs = FS_XOR; ctrl.en_alu = 1'b1; ctrl.w = 1'b1; ctrl.legal = 1'b1;
      end
      OP_ADDI: begin
        ctrl.fs = FS_ADD; ctrl.k_sel = 1'b1; ctrl.en_alu = 1'b1; ctrl.w = 1'b1;
        ctrl.setf_allowed = 1'b1; ctrl.legal = 1'b1;
      end
      OP_SUBI: begin
        ctrl.fs = FS_SUB; ctrl.c0 = 1'b1; ctrl.k_sel = 1'b1; ctrl.en_alu = 1'b1;
        ctrl.w = 1'b1; ctrl.setf_allowed = 1'b1; ctrl.legal = 1'b1;
      end
      OP_LSL: begin
        ctrl.fs = FS_LSL; ctrl.k_sel = 1'b1; ctrl.en_alu = 1'b1; ctrl.w = 1'b1;
        ctrl.legal = 1'b1;
      end
      OP_LSR: begin
        ctrl.fs = FS_LSR; ctrl.k_sel = 1'b1; ctrl.en_alu = 1'b1; ctrl.w = 1'b1;
        ctrl.legal = 1'b1;
      end
      OP_CMP: begin
        ctrl.fs = FS_SUB; ctrl.c0 = 1'b1; ctrl.en_alu = 1'b1; ctrl.legal = 1'b1;
      end
      OP_SWAP: begin
        ctrl.en_b = 1'b1; ctrl.w = 1'b1; ctrl.legal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/regfile_alu_sequencer.sv
// Command sequencer driving the 32x64 register file + ALU control word.
// One-cycle ops run in EXEC; SWAP walks SW1..SW3 through a scratch register.
module regfile_alu_sequencer
  import regfile_alu_seq_pkg::*;
#(
  parameter logic [4:0] SCRATCH_REG = 5'd30,
  parameter int         IMM_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [4:0]       cmd_rd,
  input  logic [4:0]       cmd_rn,
  input  logic [4:0]       cmd_rm,
  input  logic [IMM_W-1:0] cmd_imm,
  input  logic             cmd_setf,
  input  logic [3:0]       Status,
  output logic             W,
  output logic             EN_ALU,
  output logic             EN_B,
  output logic             K_SEL,
  output logic             C0,
  output logic [4:0]       SA,
  output logic [4:0]       SB,
  output logic [4:0]       DA,
  output logic [4:0]       FS,
  output logic [63:0]      K,
  output logic             done,
  output logic             err,
  output logic [3:0]       flags,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [3:0]       op_reg;
  logic [4:0]       rd_reg, rn_reg, rm_reg;
  logic [IMM_W-1:0] imm_reg;
  logic             setf_reg;
  logic [3:0]       flags_reg;
  op_ctrl_t         ctrl;
  logic             accept;
  logic             swap_conflict;

  assign accept        = (state_reg == ST_IDLE) && cmd_valid;
  assign swap_conflict = (cmd_rd == SCRATCH_REG) || (cmd_rn == SCRATCH_REG);

  seq_op_decode u_decode (
    .op   (op_reg),
    .ctrl (ctrl)
  );

  // State register; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Command capture at the accepting edge; fields are held until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= '0;
      rd_reg   <= '0;
      rn_reg   <= '0;
      rm_reg   <= '0;
      imm_reg  <= '0;
      setf_reg <= 1'b0;
    end else if (accept) begin
      op_reg   <= cmd_op;
      rd_reg   <= cmd_rd;
      rn_reg   <= cmd_rn;
      rm_reg   <= cmd_rm;
      imm_reg  <= cmd_imm;
      setf_reg <= cmd_setf;
    end
  end

  // Flags load from ALU Status at the end of EXEC for CMP or a flag-setting arithmetic op
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_reg <= '0;
    end else if (state_reg == ST_EXEC &&
                 (op_reg == OP_CMP || (setf_reg && ctrl.setf_allowed))) begin
      flags_reg <= Status;
    end
  end

  // Next-state selection; legality of the incoming command decides the branch
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!op_is_legal(cmd_op))                state_next = ST_ERR;
          else if (cmd_op == OP_SWAP && swap_conflict) state_next = ST_ERR;
          else if (cmd_op == OP_SWAP)              state_next = ST_SW1;
          else                                     state_next = ST_EXEC;
        end
      end
      ST_EXEC: state_next = ST_IDLE;
      ST_SW1:  state_next = ST_SW2;
      ST_SW2:  state_next = ST_SW3;
      ST_SW3:  state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Control word per state; IDLE and ERR leave the datapath fully quiet
  always_comb begin
    W      = 1'b0;
    EN_ALU = 1'b0;
    EN_B   = 1'b0;
    K_SEL  = 1'b0;
    C0     = 1'b0;
    SA     = '0;
    SB     = '0;
    DA     = '0;
    FS     = '0;
    K      = '0;
    done   = 1'b0;
    err    = 1'b0;
    unique case (state_reg)
      ST_EXEC: begin
        W      = ctrl.w;
        EN_ALU = ctrl.en_alu;
        EN_B   = ctrl.en_b;
        K_SEL  = ctrl.k_sel;
        C0     = ctrl.c0;
        FS     = ctrl.fs;
        SA     = ctrl.en_alu ? rn_reg : 5'd0;
        SB     = ctrl.en_b ? rn_reg : (ctrl.en_alu ? rm_reg : 5'd0);
        DA     = rd_reg;
        K      = ctrl.k_sel ? 64'(imm_reg) : 64'd0;
        done   = ctrl.legal;
      end
      ST_SW1: begin
        W = 1'b1; EN_B = 1'b1; SB = rn_reg; DA = SCRATCH_REG;
      end
      ST_SW2: begin
        W = 1'b1; EN_B = 1'b1; SB = rd_reg; DA = rn_reg;
      end
      ST_SW3: begin
        W = 1'b1; EN_B = 1'b1; SB = SCRATCH_REG; DA = rd_reg; done = 1'b1;
      end
      ST_ERR:  err = 1'b1;
      default: ;
    endcase
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign flags     = flags_reg;

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Directed bench: a behavioural 32x64 register file and ALU close the loop
// around the sequencer so register contents and Status are realistic.
module tb_regfile_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [11:0] cmd_imm;
  logic        cmd_setf;
  logic [3:0]  Status;
  logic        W, EN_ALU, EN_B, K_SEL, C0;
  logic [4:0]  SA, SB, DA, FS;
  logic [63:0] K;
  logic        done, err, busy;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  regfile_alu_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .cmd_setf(cmd_setf), .Status(Status),
    .W(W), .EN_ALU(EN_ALU), .EN_B(EN_B), .K_SEL(K_SEL), .C0(C0),
    .SA(SA), .SB(SB), .DA(DA), .FS(FS), .K(K),
    .done(done), .err(err), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath model: register file, B-mux, ALU with {V,C,N,Z} status
  logic [63:0] regs [32] = '{default: 64'd0};
  logic [63:0] a_in, b_reg, b_mux, b_in, res, bus;
  logic        carry, ovf;

  always_comb begin
    b_reg = regs[SB];
    b_mux = K_SEL ? K : b_reg;
    a_in  = FS[1] ? ~regs[SA] : regs[SA];
    b_in  = FS[0] ? ~b_mux : b_mux;
    res   = 64'd0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (FS[4:2])
      3'd0: res = a_in & b_in;
      3'd1: res = a_in | b_in;
      3'd2: begin
        {carry, res} = {1'b0, a_in} + {1'b0, b_in} + {64'd0, C0};
        ovf = (a_in[63] == b_in[63]) && (res[63] != a_in[63]);
      end
      3'd3: res = a_in ^ b_in;
      3'd4: res = a_in << b_in[5:0];
      3'd5: res = a_in >> b_in[5:0];
      default: res = 64'd0;
    endcase
    Status = {ovf, carry, res[63], (res == 64'd0)};
    bus    = EN_ALU ? res : (EN_B ? b_reg : 64'd0);
  end

  always @(posedge clk) begin
    if (W) regs[DA] <= bus;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one accepting edge, then scramble the inputs
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [11:0] imm, input logic setf);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rn = rn;
    cmd_rm = rm; cmd_imm = imm; cmd_setf = setf;
    tick();
    $display("cmd op=%h rd=%0d rn=%0d rm=%0d imm=%0d setf=%0b", op, rd, rn, rm, imm, setf);
    cmd_valid = 1'b0; cmd_op = 4'hE; cmd_rd = 5'd0; cmd_rn = 5'd0;
    cmd_rm = 5'd0; cmd_imm = 12'hFFF; cmd_setf = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_rd = 5'd0; cmd_rn = 5'd0;
    cmd_rm = 5'd0; cmd_imm = 12'd0; cmd_setf = 1'b0;
    tick(); tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy",  busy, 0);
    chk("rst_flags", flags, 0);
    chk("rst_ctrl",  {W, EN_ALU, EN_B, K_SEL, C0, done, err}, 0);
    chk("rst_addr",  {SA, SB, DA, FS}, 0);
    chk("rst_k",     K, 0);
    rst = 1'b0;
    tick();

    // ADDI r1 = r31 + 5
    send(4'h6, 5'd1, 5'd31, 5'd0, 12'd5, 1'b0);
    chk("addi_ready", cmd_ready, 0);
    chk("addi_k",     K, 64'd5);
    chk("addi_ctl",   {K_SEL, EN_ALU, EN_B, W, C0, done}, 6'b110101);
    chk("addi_fs",    FS, 5'b01000);
    chk("addi_da",    DA, 5'd1);
    chk("addi_sa",    SA, 5'd31);
    tick();
    chk("addi_ready2", cmd_ready, 1);
    chk("addi_done0",  done, 0);
    chk("addi_r1",     regs[1], 64'd5);

    send(4'h6, 5'd2, 5'd31, 5'd0, 12'd7, 1'b0); tick();
    send(4'h6, 5'd4, 5'd31, 5'd0, 12'd5, 1'b0); tick();
    chk("setup_r2", regs[2], 64'd7);
    chk("setup_r4", regs[4], 64'd5);

    // SUB r3 = r1 - r2 with flags
    send(4'h2, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);
    chk("sub_c0",   C0, 1);
    chk("sub_fs",   FS, 5'b01001);
    chk("sub_srcs", {SA, SB, DA}, {5'd1, 5'd2, 5'd3});
    tick();
    chk("sub_r3",    regs[3], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_flags", flags, 4'b0010);

    // CMP r1, r4: no write, flags always
    send(4'hA, 5'd3, 5'd1, 5'd4, 12'd0, 1'b0);
    chk("cmp_w",  W, 0);
    chk("cmp_fs", {FS, C0, EN_ALU}, {5'b01001, 2'b11});
    tick();
    chk("cmp_w2",    W, 0);
    chk("cmp_r3",    regs[3], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("cmp_flags", flags, 4'b0101);

    // ADD without setf leaves flags alone
    send(4'h1, 5'd5, 5'd1, 5'd2, 12'd0, 1'b0); tick();
    chk("add_r5",    regs[5], 64'd12);
    chk("add_flags", flags, 4'b0101);

    // MOV r6 = r3; setf ignored
    send(4'h0, 5'd6, 5'd3, 5'd0, 12'd0, 1'b1);
    chk("mov_ctl", {EN_B, EN_ALU, W, K_SEL, C0}, 5'b10100);
    chk("mov_sb",  SB, 5'd3);
    chk("mov_fs",  FS, 0);
    tick();
    chk("mov_r6",    regs[6], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mov_flags", flags, 4'b0101);

    // LSL r7 = r1 << 4
    send(4'h8, 5'd7, 5'd1, 5'd0, 12'd4, 1'b0);
    chk("lsl_fs", {FS, K_SEL}, {5'b10000, 1'b1});
    tick();
    chk("lsl_r7", regs[7], 64'h50);

    // EOR r8 = r1 ^ r2
    send(4'h5, 5'd8, 5'd1, 5'd2, 12'd0, 1'b0);
    chk("eor_fs", FS, 5'b01100);
    tick();
    chk("eor_r8", regs[8], 64'd2);

    // SWAP r1(5) <-> r2(7) via r30
    send(4'hB, 5'd1, 5'd2, 5'd0, 12'd0, 1'b0);
    chk("sw1_ctl", {EN_B, W, EN_ALU, done}, 4'b1100);
    chk("sw1_adr", {SB, DA}, {5'd2, 5'd30});
    tick();
    chk("sw2_ctl", {EN_B, W, EN_ALU, done}, 4'b1100);
    chk("sw2_adr", {SB, DA}, {5'd1, 5'd2});
    tick();
    chk("sw3_ctl", {EN_B, W, EN_ALU, done}, 4'b1101);
    chk("sw3_adr", {SB, DA}, {5'd30, 5'd1});
    tick();
    chk("swap_idle", {cmd_ready, done}, 2'b10);
    chk("swap_r1",   regs[1], 64'd7);
    chk("swap_r2",   regs[2], 64'd5);
    chk("swap_r30",  regs[30], 64'd7);

    // SUBI r9 = r2(5) - 6 with flags
    send(4'h7, 5'd9, 5'd2, 5'd0, 12'd6, 1'b1); tick();
    chk("subi_r9",    regs[9], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("subi_flags", flags, 4'b0010);

    // Illegal opcode
    send(4'hD, 5'd1, 5'd2, 5'd3, 12'd9, 1'b1);
    chk("ill_err",  {err, busy, cmd_ready, done, W}, 5'b11000);
    chk("ill_quiet", {SA, SB, DA, FS, EN_ALU, EN_B, K_SEL, C0}, 0);
    chk("ill_k",    K, 0);
    tick();
    chk("ill_idle",  {err, cmd_ready}, 2'b01);
    chk("ill_flags", flags, 4'b0010);
    chk("ill_r1",    regs[1], 64'd7);

    // SWAP naming the scratch register
    send(4'hB, 5'd30, 5'd1, 5'd0, 12'd0, 1'b0);
    chk("swx_err", {err, W, EN_B}, 3'b100);
    tick();
    chk("swx_idle", {err, cmd_ready}, 2'b01);
    chk("swx_r1",   regs[1], 64'd7);
    chk("swx_r30",  regs[30], 64'd7);

    // Reset during SW2 of SWAP r1(7) <-> r5(12)
    send(4'hB, 5'd1, 5'd5, 5'd0, 12'd0, 1'b0);
    tick();
    chk("rsw_sw2", DA, 5'd5);
    rst = 1'b1;
    tick();
    chk("rsw_ctrl",  {W, EN_ALU, EN_B, K_SEL, C0, done, err, busy}, 0);
    chk("rsw_addr",  {SA, SB, DA, FS}, 0);
    chk("rsw_ready", cmd_ready, 1);
    chk("rsw_flags", flags, 0);
    chk("rsw_r30",   regs[30], 64'd12);
    chk("rsw_r1",    regs[1], 64'd7);

    // Handshake during reset is not accepted
    cmd_valid = 1'b1; cmd_op = 4'h6; cmd_rd = 5'd10; cmd_rn = 5'd31; cmd_imm = 12'd3;
    tick();
    chk("rhs_busy", {busy, cmd_ready}, 2'b01);
    rst = 1'b0; cmd_valid = 1'b0;
    tick();
    chk("rhs_idle", {busy, W}, 0);
    chk("rhs_r10",  regs[10], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
